// File: rtl/keypad_event_queue.sv
// Debounced active-low keypad that queues press events (key index) in a FIFO,
// with an optional auto-repeat of the most recently pressed key.
module keypad_event_queue #(
    parameter  int unsigned NKEYS      = 16,
    parameter  int unsigned DEB_CYC    = 4,
    parameter  int unsigned DEPTH      = 4,
    parameter  int unsigned REPEAT_EN  = 0,
    parameter  int unsigned REPEAT_CYC = 64,
    localparam int unsigned KEY_W      = $clog2(NKEYS),
    localparam int unsigned LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic             sw_clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] pb,
    input  logic             key_ready,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic             key_down,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned RPT_W = $clog2(REPEAT_CYC);

    typedef enum logic {S_IDLE, S_ARMED} rpt_state_e;

    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [NKEYS-1:0] pressed_q, pressed_prev_q, differs, new_press;
    logic [7:0]       deb_cnt_q [NKEYS];
    logic             key_down_q;
    logic             ev_valid_q;
    logic [KEY_W-1:0] ev_code_q, new_code;

    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rcnt_q, rcnt_d;
    logic [KEY_W-1:0] rkey_q, rkey_d;
    logic             rep_push;

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             overflow_q;
    logic             push, pop, full, wr_en;
    logic [KEY_W-1:0] push_code;

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= pb;
            sync2_q <= sync1_q;
        end
    end

    // pressed_q is active-high, synced inputs are active-low
    assign differs = ~sync2_q ^ pressed_q;

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            pressed_q      <= '0;
            pressed_prev_q <= '0;
            key_down_q     <= 1'b0;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            pressed_prev_q <= pressed_q;
            key_down_q     <= |pressed_q;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                if (!differs[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == 8'(DEB_CYC - 1)) begin
                    deb_cnt_q[i] <= '0;
                    pressed_q[i] <= ~pressed_q[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign new_press = pressed_q & ~pressed_prev_q;

    // Descending scan so the lowest simultaneous press wins
    always_comb begin
        new_code = '0;
        for (int unsigned i = NKEYS; i > 0; i--) begin
            if (new_press[i-1]) new_code = KEY_W'(i - 1);
        end
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            ev_valid_q <= 1'b0;
            ev_code_q  <= '0;
        end else begin
            ev_valid_q <= |new_press;
            ev_code_q  <= new_code;
        end
    end

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        rkey_d   = rkey_q;
        rep_push = 1'b0;
        if (REPEAT_EN != 0) begin
            case (state_q)
                S_IDLE: begin
                    if (ev_valid_q) begin
                        state_d = S_ARMED;
                        rkey_d  = ev_code_q;
                        rcnt_d  = '0;
                    end
                end
                S_ARMED: begin
                    if (ev_valid_q) begin
                        rkey_d = ev_code_q;
                        rcnt_d = '0;
                    end else if (!pressed_q[rkey_q]) begin
                        state_d = S_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RPT_W'(REPEAT_CYC - 1)) begin
                        rep_push = 1'b1;
                        rcnt_d   = '0;
                    end else begin
                        rcnt_d = rcnt_q + RPT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            rkey_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            rkey_q  <= rkey_d;
        end
    end

    assign push      = ev_valid_q | rep_push;
    assign push_code = ev_valid_q ? ev_code_q : rkey_q;
    assign pop       = key_valid & key_ready;
    assign full      = (level_q == LVL_W'(DEPTH));
    assign wr_en     = push & (~full | pop);

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (wr_en && !pop)      level_q <= level_q + LVL_W'(1);
            else if (pop && !wr_en) level_q <= level_q - LVL_W'(1);
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge sw_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_code;
    end

    assign key_valid  = (level_q != '0);
    assign key_code   = key_valid ? mem_q[rd_ptr_q] : '0;
    assign key_down   = key_down_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Bench for keypad_event_queue: a repeat-off and a repeat-on instance share
// stimulus and are compared every cycle against an event-timeline model.
module tb_keypad_event_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pb;
    logic        key_ready;

    logic       kv0, kd0, ov0, kv1, kd1, ov1;
    logic [3:0] kc0, kc1;
    logic [2:0] lvl0, lvl1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_event_queue #(.NKEYS(16), .DEB_CYC(4), .DEPTH(4), .REPEAT_EN(0), .REPEAT_CYC(64)) dut0 (
        .sw_clk(clk), .rst(rst), .pb(pb), .key_ready(key_ready),
        .key_valid(kv0), .key_code(kc0), .key_down(kd0), .fifo_level(lvl0), .overflow(ov0)
    );

    keypad_event_queue #(.NKEYS(16), .DEB_CYC(4), .DEPTH(4), .REPEAT_EN(1), .REPEAT_CYC(16)) dut1 (
        .sw_clk(clk), .rst(rst), .pb(pb), .key_ready(key_ready),
        .key_valid(kv1), .key_code(kc1), .key_down(kd1), .fifo_level(lvl1), .overflow(ov1)
    );

    // Reference model: index 0 = repeat off, 1 = repeat every 16 edges
    logic [15:0] pb_d1, pb_d2;
    logic [15:0] m_deb [2];
    logic [15:0] m_rose1 [2];
    logic [15:0] m_rose2 [2];
    int          m_run [2][16];
    bit          m_armed [2];
    int          m_rkey [2];
    longint      m_next [2];
    longint      m_t = 0;
    int          m_fifo [2][16];
    int          m_cnt [2];
    bit          m_ovf [2];
    bit          m_kd [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pb_d1 = '1;
        pb_d2 = '1;
        for (int m = 0; m < 2; m++) begin
            m_deb[m] = '0; m_rose1[m] = '0; m_rose2[m] = '0;
            m_armed[m] = 0; m_rkey[m] = 0; m_next[m] = 0;
            m_cnt[m] = 0; m_ovf[m] = 0; m_kd[m] = 0;
            for (int k = 0; k < 16; k++) m_run[m][k] = 0;
        end
    endtask

    task automatic model_step();
        logic [15:0] sync_pr;
        sync_pr = ~pb_d2;
        for (int m = 0; m < 2; m++) begin
            logic [15:0] deb_b;
            logic [15:0] rose;
            int press;
            int push;
            bit pop;
            deb_b = m_deb[m];
            press = -1;
            push  = -1;
            for (int k = 15; k >= 0; k--) if (m_rose2[m][k]) press = k;
            pop = (m_cnt[m] > 0) && key_ready;
            if (press >= 0) begin
                push = press;
                if (m == 1) begin
                    m_armed[m] = 1;
                    m_rkey[m]  = press;
                    m_next[m]  = m_t + 16;
                end
            end else if (m_armed[m]) begin
                if (!deb_b[m_rkey[m]]) m_armed[m] = 0;
                else if (m_t == m_next[m]) begin
                    push      = m_rkey[m];
                    m_next[m] = m_t + 16;
                end
            end
            if (pop) begin
                for (int j = 0; j < 15; j++) m_fifo[m][j] = m_fifo[m][j+1];
                m_cnt[m]--;
            end
            if (push >= 0) begin
                if (m_cnt[m] < 4) begin
                    m_fifo[m][m_cnt[m]] = push;
                    m_cnt[m]++;
                end else begin
                    m_ovf[m] = 1;
                end
            end
            m_kd[m] = |deb_b;
            for (int k = 0; k < 16; k++) begin
                if (sync_pr[k] != deb_b[k]) begin
                    m_run[m][k]++;
                    if (m_run[m][k] == 4) begin
                        m_deb[m][k] = sync_pr[k];
                        m_run[m][k] = 0;
                    end
                end else begin
                    m_run[m][k] = 0;
                end
            end
            rose = m_deb[m] & ~deb_b;
            m_rose2[m] = m_rose1[m];
            m_rose1[m] = rose;
        end
        pb_d2 = pb_d1;
        pb_d1 = pb;
        m_t++;
    endtask

    always @(posedge clk) if (rst) model_step();

    task automatic check_model();
        chk("m0_valid", 32'(kv0),  32'(m_cnt[0] != 0));
        chk("m0_code",  32'(kc0),  (m_cnt[0] != 0) ? 32'(m_fifo[0][0]) : 32'd0);
        chk("m0_level", 32'(lvl0), 32'(m_cnt[0]));
        chk("m0_ovf",   32'(ov0),  32'(m_ovf[0]));
        chk("m0_down",  32'(kd0),  32'(m_kd[0]));
        chk("m1_valid", 32'(kv1),  32'(m_cnt[1] != 0));
        chk("m1_code",  32'(kc1),  (m_cnt[1] != 0) ? 32'(m_fifo[1][0]) : 32'd0);
        chk("m1_level", 32'(lvl1), 32'(m_cnt[1]));
        chk("m1_ovf",   32'(ov1),  32'(m_ovf[1]));
        chk("m1_down",  32'(kd1),  32'(m_kd[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    // Called at a negedge; releases reset before the next posedge
    task automatic reset_pulse();
        #2 rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
    endtask

    int ev_t [8];
    int n0, n1;
    int codes [4];

    initial begin
        rst = 1'b0;
        pb = '1;
        key_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(kv0), 0);
        chk("rst_code",  32'(kc0), 0);
        chk("rst_level", 32'(lvl0), 0);
        chk("rst_down",  32'(kd0), 0);
        chk("rst_ovf",   32'(ov0), 0);
        rst = 1'b1;
        repeat (3) tick();

        // Single press latency and key_down
        reset_pulse();
        pb[3] = 1'b0;
        repeat (7) tick();
        chk("lat_pre_valid", 32'(kv0), 0);
        tick();
        chk("lat_valid", 32'(kv0), 1);
        chk("lat_code",  32'(kc0), 3);
        chk("lat_level", 32'(lvl0), 1);
        chk("lat_down",  32'(kd0), 1);
        repeat (12) tick();
        pb[3] = 1'b1;
        repeat (20) tick();
        chk("lat_one_event", 32'(lvl0), 1);

        // Short bounces are filtered
        reset_pulse();
        pb[5] = 1'b0; repeat (2) tick();
        pb[5] = 1'b1; tick();
        pb[5] = 1'b0; repeat (3) tick();
        pb[5] = 1'b1; repeat (2) tick();
        pb[5] = 1'b0; repeat (7) tick();
        chk("bounce_pre_valid", 32'(kv0), 0);
        tick();
        chk("bounce_valid", 32'(kv0), 1);
        chk("bounce_code",  32'(kc0), 5);
        repeat (2) tick();
        pb[5] = 1'b1;
        repeat (10) tick();
        chk("bounce_level", 32'(lvl0), 1);

        // Overflow, then ordered drain
        reset_pulse();
        codes = '{1, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            int k;
            k = (i < 4) ? codes[i] : 6;
            pb[k] = 1'b0; repeat (8) tick();
            pb[k] = 1'b1; repeat (8) tick();
        end
        chk("ovf_level", 32'(lvl0), 4);
        chk("ovf_flag",  32'(ov0), 1);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_code", 32'(kc0), 32'(codes[i]));
            tick();
        end
        chk("drain_empty", 32'(kv0), 0);
        chk("drain_ovf",   32'(ov0), 1);
        key_ready = 1'b0;

        // Simultaneous presses: lowest index only
        reset_pulse();
        pb[9] = 1'b0;
        pb[2] = 1'b0;
        repeat (20) tick();
        chk("simul_level", 32'(lvl0), 1);
        chk("simul_code",  32'(kc0), 2);
        chk("simul_ovf",   32'(ov0), 0);
        pb = '1;
        repeat (10) tick();

        // Auto-repeat on held key 7
        reset_pulse();
        key_ready = 1'b1;
        n0 = 0;
        n1 = 0;
        pb[7] = 1'b0;
        for (int i = 0; i < 110; i++) begin
            if (i == 63) pb[7] = 1'b1;
            tick();
            if (kv0 && kc0 == 4'd7) n0++;
            if (kv1 && kc1 == 4'd7) begin
                if (n1 < 8) ev_t[n1] = i;
                n1++;
            end
        end
        chk("rpt_off_count", 32'(n0), 1);
        chk("rpt_on_count",  32'(n1), 4);
        chk("rpt_first",     32'(ev_t[0]), 7);
        for (int i = 1; i < 4 && i < n1; i++) chk("rpt_gap", 32'(ev_t[i] - ev_t[i-1]), 16);
        key_ready = 1'b0;

        // Async reset with key 4 held
        reset_pulse();
        pb[1] = 1'b0; repeat (8) tick();
        pb[1] = 1'b1; repeat (8) tick();
        pb[2] = 1'b0; repeat (8) tick();
        pb[2] = 1'b1; repeat (8) tick();
        pb[4] = 1'b0; repeat (10) tick();
        chk("ar_level_pre", 32'(lvl0), 3);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", 32'(kv0), 0);
        chk("ar_code",  32'(kc0), 0);
        chk("ar_down",  32'(kd0), 0);
        chk("ar_level", 32'(lvl0), 0);
        chk("ar_ovf1",  32'(ov1), 0);
        model_reset();
        #1 rst = 1'b1;
        repeat (7) tick();
        chk("ar_pre_valid", 32'(kv0), 0);
        tick();
        chk("ar_post_valid", 32'(kv0), 1);
        chk("ar_post_code",  32'(kc0), 4);
        chk("ar_post_level", 32'(lvl0), 1);
        pb = '1;
        repeat (10) tick();

        // Randomized traffic against the model
        reset_pulse();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 39) == 0) pb[k] = ~pb[k];
            end
            if (((c / 150) % 2) == 0) key_ready = ($urandom_range(0, 1) == 1);
            else                      key_ready = ($urandom_range(0, 7) == 0);
            if (c == 1500) reset_pulse();
            tick();
        end
        pb = '1;
        key_ready = 1'b1;
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_event_queue.md
KEYPAD_EVENT_QUEUE -- requirements
Module: keypad_event_queue

Interface
REQ-001 Parameter NKEYS, 16, number of active-low push-button inputs (2..32).
REQ-002 Parameter DEB_CYC, 4, consecutive stable sw_clk cycles required to accept a level change (1..255).
REQ-003 Parameter DEPTH, 4, event FIFO entries (power of two, 2..16).
REQ-004 Parameter REPEAT_EN, 0, 1 enables auto-repeat of held key.
REQ-005 Parameter REPEAT_CYC, 64, auto-repeat interval in sw_clk cycles (>= 2).
REQ-006 KEY_W = clog2(NKEYS), LVL_W = clog2(DEPTH)+1 (derived, not overridable).
REQ-007 sw_clk  in  1  sole clock; all state on rising edge.
REQ-008 rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-009 pb  in  NKEYS  raw key inputs, 0 = pressed, asynchronous to sw_clk.
REQ-010 key_ready  in  1  consumer accepts head event this cycle.
REQ-011 key_valid  out  1  FIFO non-empty; head event presented.
REQ-012 key_code  out  KEY_W  index of pressed key at FIFO head.
REQ-013 key_down  out  1  at least one debounced key currently pressed.
REQ-014 fifo_level  out  LVL_W  number of stored events (0..DEPTH).
REQ-015 overflow  out  1  sticky: an event was dropped because FIFO was full.

Function
REQ-016 Each pb bit SHALL pass a 2-flop synchronizer (sync value = 1 after reset).
REQ-017 Per key, a counter SHALL increment each edge the synced value differs from the debounced state and clear to 0 on any edge it matches.
REQ-018 Debounced state SHALL take the synced value on the edge the counter reaches DEB_CYC; counter clears on that edge.
REQ-019 A press event SHALL be generated for key i on the edge after its debounced state goes released->pressed; release generates no event.
REQ-020 Multiple new presses in one cycle: only lowest index SHALL be pushed; others discarded without setting overflow.
REQ-021 Latency: pb level stable from edge 0 -> event pushed at edge DEB_CYC+3, key_valid high after that edge when FIFO was empty.
REQ-022 Auto-repeat FSM (REPEAT_EN=1), states IDLE, ARMED, each with counter: IDLE->ARMED on any press event, latching that key; in ARMED counter increments per edge, at REPEAT_CYC push latched key again and clear counter; new press of any key re-latches and clears counter; debounced release of latched key -> IDLE.
REQ-023 Repeat push and press push in same cycle: press push wins, counter clears.
REQ-024 With REPEAT_EN=0 the FSM SHALL stay in IDLE and generate no repeats.
REQ-025 FIFO: key_valid = (fifo_level != 0); key_code = head entry, 0 when empty.
REQ-026 Pop occurs on edge with key_valid & key_ready; key_ready while empty has no effect.
REQ-027 Push when level < DEPTH stores event at tail; level +1.
REQ-028 Push when full without pop: event dropped, overflow set, level stays DEPTH.
REQ-029 Push and pop same edge: both occur, level unchanged, including when full (no overflow).
REQ-030 Read/write pointers SHALL wrap modulo DEPTH; event order strictly FIFO.
REQ-031 key_down SHALL be OR of debounced pressed states, registered.

Reset
REQ-032 While rst=0, asynchronously: sync flops and debounced states = released, debounce/repeat counters 0, FSM IDLE, pointers 0.
REQ-033 Outputs during/after reset: key_valid 0, key_code 0, key_down 0, fifo_level 0, overflow 0.
REQ-034 Only rst clears overflow; keys held through reset release SHALL produce a fresh press event DEB_CYC+3 edges after rst deassertion.

Verification (NKEYS=16, DEB_CYC=4, DEPTH=4 unless stated)
REQ-035 key_ready=0, pb[3] low 20 cycles -> key_valid rises at edge 7, key_code=3, fifo_level=1, key_down=1; exactly one event.
REQ-036 pb[5] low 2 cycles, high 1, low 3, high 2, low 10 -> exactly one event code 5 at edge 7 of final low period; no events from short pulses.
REQ-037 key_ready=0, press/release keys 1,2,3,4,6 in turn -> fifo_level=4, overflow=1; then key_ready=1 pops 1,2,3,4 then key_valid=0, overflow stays 1.
REQ-038 pb[9] and pb[2] go low same cycle -> single event code 2; fifo_level=1.
REQ-039 REPEAT_EN=1, REPEAT_CYC=16, key_ready=1, hold key 7 for 60 cycles after its event -> 4 total events code 7 spaced 16 edges apart; release -> no further events.
REQ-040 fifo_level=3 with key 4 held, pulse rst low mid-cycle -> all outputs 0 immediately; after release, event code 4 at edge 7.
